// File: rtl/register_lanes_if.sv
// Bus bundle for register_lanes: parallel/serial load controls plus register state.
//   lane_in   : parallel data, lane k at [(k+1)*W-1 : k*W]
//   load      : per-lane parallel load enable
//   ser_start : request a serial fill
//   ser_valid : ser_in carries a lane word this cycle
//   ser_in    : serial lane word
//   out       : register contents
//   busy      : serial fill in progress
//   done      : one-cycle pulse after a serial fill completes
//   parity    : per-lane XOR (only with REGISTER_LANES_PARITY_EN)
// Optional feature macro: REGISTER_LANES_PARITY_EN
interface register_lanes_if #(
  parameter int unsigned N     = 32,
  parameter int unsigned LANES = 4
);
  localparam int unsigned W = N / LANES;

  logic [N-1:0]     lane_in;
  logic [LANES-1:0] load;
  logic             ser_start;
  logic             ser_valid;
  logic [W-1:0]     ser_in;
  logic [N-1:0]     out;
  logic             busy;
  logic             done;
`ifdef REGISTER_LANES_PARITY_EN
  logic [LANES-1:0] parity;

  modport master (
    output lane_in, load, ser_start, ser_valid, ser_in,
    input  out, busy, done, parity
  );

  modport slave (
    input  lane_in, load, ser_start, ser_valid, ser_in,
    output out, busy, done, parity
  );
`else
  modport master (
    output lane_in, load, ser_start, ser_valid, ser_in,
    input  out, busy, done
  );

  modport slave (
    input  lane_in, load, ser_start, ser_valid, ser_in,
    output out, busy, done
  );
`endif

endinterface

// File: rtl/register_lanes.sv
// register_lanes: N-bit register split into LANES lanes of W bits, loaded either
// per lane in parallel (IDLE) or by a serial fill from lane LANES-1 down to lane 0.
// Ports:
//   clk     : sole clock, rising edge
//   clear_n : asynchronous active-low reset
//   bus     : register_lanes_if.slave (see interface file for signal list)
// Optional feature macro: REGISTER_LANES_PARITY_EN adds a registered per-lane
// XOR output (bus.parity); without it the parity port and logic are absent.
module register_lanes #(
  parameter int unsigned N     = 32,
  parameter int unsigned LANES = 4
) (
  input  logic           clk,
  input  logic           clear_n,
  register_lanes_if.slave bus
);

  localparam int unsigned W  = N / LANES;
  localparam int unsigned PW = $clog2(LANES);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_ptr_nxt;
  logic [N-1:0]  r_reg;
  logic [N-1:0]  w_reg_nxt;
  logic          r_done;
  logic          w_done_nxt;

  // State, pointer, register and done pulse.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_reg   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_reg   <= w_reg_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Next-state and next-register logic.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_reg_nxt   = r_reg;
    w_done_nxt  = 1'b0;
    unique case (r_state)
      IDLE: begin
        // Parallel load still applies on the edge that starts a fill.
        for (int unsigned k = 0; k < LANES; k++) begin
          if (bus.load[k]) begin
            w_reg_nxt[k*W +: W] = bus.lane_in[k*W +: W];
          end
        end
        if (bus.ser_start) begin
          w_state_nxt = FILL;
          w_ptr_nxt   = PW'(LANES - 1);
        end
      end
      FILL: begin
        // load/ser_start ignored here; ser_valid low stalls everything.
        if (bus.ser_valid) begin
          w_reg_nxt[int'(r_ptr)*W +: W] = bus.ser_in;
          if (r_ptr == '0) begin
            w_state_nxt = IDLE;
            w_done_nxt  = 1'b1;
          end else begin
            w_ptr_nxt = r_ptr - PW'(1);
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign bus.out  = r_reg;
  assign bus.busy = (r_state == FILL);
  assign bus.done = r_done;

`ifdef REGISTER_LANES_PARITY_EN
  logic [LANES-1:0] r_parity;
  logic [LANES-1:0] w_parity_nxt;

  // Parity is taken from the next register value so it tracks the lane edge-for-edge.
  always_comb begin
    w_parity_nxt = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      w_parity_nxt[k] = ^w_reg_nxt[k*W +: W];
    end
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      r_parity <= '0;
    end else begin
      r_parity <= w_parity_nxt;
    end
  end

  assign bus.parity = r_parity;
`endif

endmodule

// File: tb/tb_register_lanes.sv
// Self-checking bench for register_lanes (N=32, LANES=4).
module tb_register_lanes;

  localparam int unsigned N     = 32;
  localparam int unsigned LANES = 4;
  localparam int unsigned W     = N / LANES;

  typedef struct {
    logic [N-1:0]     lane_in;
    logic [LANES-1:0] load;
    logic             start;
    logic             valid;
    logic [W-1:0]     ser_in;
    logic [N-1:0]     exp_out;
    logic             exp_busy;
    logic             exp_done;
  } vec_t;

  typedef struct {
    logic [N-1:0] out;
    logic         busy;
    logic         done;
  } exp_t;

  logic clk;
  logic clear_n;
  int   n_cmp;
  int   n_err;
  exp_t sb_q[$];
  vec_t vec[24];

  register_lanes_if #(.N(N), .LANES(LANES)) bus_if ();

  register_lanes #(.N(N), .LANES(LANES)) dut (
    .clk     (clk),
    .clear_n (clear_n),
    .bus     (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run time expired (act=timeout, exp=finish)");
    $fatal(1, "watchdog");
  end

  function automatic logic [LANES-1:0] parity_of(input logic [N-1:0] v);
    logic [LANES-1:0] p;
    for (int k = 0; k < int'(LANES); k++) p[k] = ^v[k*W +: W];
    return p;
  endfunction

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_state(input string name, input exp_t e);
    chk({name, ".out"},  bus_if.out,  e.out);
    chk({name, ".busy"}, N'(bus_if.busy), N'(e.busy));
    chk({name, ".done"}, N'(bus_if.done), N'(e.done));
`ifdef REGISTER_LANES_PARITY_EN
    chk({name, ".parity"}, N'(bus_if.parity), N'(parity_of(e.out)));
`endif
  endtask

  task automatic drive(input logic [N-1:0] li, input logic [LANES-1:0] ld,
                       input logic st, input logic vl, input logic [W-1:0] si);
    bus_if.lane_in   = li;
    bus_if.load      = ld;
    bus_if.ser_start = st;
    bus_if.ser_valid = vl;
    bus_if.ser_in    = si;
  endtask

  // Drive one cycle, queue the expected post-edge state, then pop and compare after the edge.
  task automatic step(input string name, input logic [N-1:0] li, input logic [LANES-1:0] ld,
                      input logic st, input logic vl, input logic [W-1:0] si,
                      input logic [N-1:0] eo, input logic eb, input logic ed);
    exp_t e;
    drive(li, ld, st, vl, si);
    e.out = eo; e.busy = eb; e.done = ed;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      n_cmp++; n_err++;
      $display("FAIL %s: scoreboard empty (act=0 entries, exp=1)", name);
    end else begin
      e = sb_q.pop_front();
      chk_state(name, e);
    end
  endtask

  function automatic vec_t mk(input logic [N-1:0] li, input logic [LANES-1:0] ld,
                              input logic st, input logic vl, input logic [W-1:0] si,
                              input logic [N-1:0] eo, input logic eb, input logic ed);
    vec_t v;
    v.lane_in = li; v.load = ld; v.start = st; v.valid = vl; v.ser_in = si;
    v.exp_out = eo; v.exp_busy = eb; v.exp_done = ed;
    return v;
  endfunction

  initial begin
    exp_t z;
    n_cmp = 0;
    n_err = 0;
    z.out = '0; z.busy = 1'b0; z.done = 1'b0;

    vec[0]  = mk(32'h11223344, 4'b0101, 0, 0, 8'h00, 32'h00220044, 0, 0);
    vec[1]  = mk(32'hAABBCCDD, 4'b1010, 0, 0, 8'h00, 32'hAA22CC44, 0, 0);
    vec[2]  = mk(32'h00000000, 4'b0000, 0, 1, 8'hFF, 32'hAA22CC44, 0, 0);
    vec[3]  = mk(32'hFFFFFFFF, 4'b0000, 0, 0, 8'h00, 32'hAA22CC44, 0, 0);
    vec[4]  = mk(32'h000000EE, 4'b0001, 1, 0, 8'h00, 32'hAA22CCEE, 1, 0);
    vec[5]  = mk(32'h00000000, 4'b0000, 0, 1, 8'h12, 32'h1222CCEE, 1, 0);
    vec[6]  = mk(32'h00000000, 4'b0000, 0, 1, 8'h34, 32'h1234CCEE, 1, 0);
    vec[7]  = mk(32'h00000000, 4'b0000, 0, 1, 8'h56, 32'h123456EE, 1, 0);
    vec[8]  = mk(32'h00000000, 4'b0000, 0, 1, 8'h78, 32'h12345678, 0, 1);
    vec[9]  = mk(32'h00000000, 4'b0000, 0, 0, 8'h00, 32'h12345678, 0, 0);
    vec[10] = mk(32'h00000000, 4'b0000, 1, 0, 8'h00, 32'h12345678, 1, 0);
    vec[11] = mk(32'h00000000, 4'b0000, 0, 1, 8'hA0, 32'hA0345678, 1, 0);
    vec[12] = mk(32'hFFFFFFFF, 4'b1111, 1, 0, 8'h99, 32'hA0345678, 1, 0);
    vec[13] = mk(32'hFFFFFFFF, 4'b1111, 1, 0, 8'h99, 32'hA0345678, 1, 0);
    vec[14] = mk(32'hFFFFFFFF, 4'b1111, 1, 0, 8'h99, 32'hA0345678, 1, 0);
    vec[15] = mk(32'h00000000, 4'b0000, 0, 1, 8'hB1, 32'hA0B15678, 1, 0);
    vec[16] = mk(32'h00000000, 4'b0000, 0, 1, 8'hC2, 32'hA0B1C278, 1, 0);
    vec[17] = mk(32'h00000000, 4'b0000, 0, 1, 8'hD3, 32'hA0B1C2D3, 0, 1);
    vec[18] = mk(32'h00000000, 4'b0000, 1, 0, 8'h00, 32'hA0B1C2D3, 1, 0);
    vec[19] = mk(32'h00000000, 4'b0000, 0, 1, 8'h01, 32'h01B1C2D3, 1, 0);
    vec[20] = mk(32'h00000000, 4'b0000, 0, 1, 8'h03, 32'h0103C2D3, 1, 0);
    vec[21] = mk(32'h00000000, 4'b0000, 0, 1, 8'h07, 32'h010307D3, 1, 0);
    vec[22] = mk(32'h00000000, 4'b0000, 0, 1, 8'h00, 32'h01030700, 0, 1);
    vec[23] = mk(32'h00000000, 4'b0000, 0, 0, 8'h00, 32'h01030700, 0, 0);

    // Power-on reset.
    clear_n = 1'b0;
    drive('0, '0, 1'b0, 1'b0, '0);
    repeat (2) @(posedge clk);
    #1;
    chk_state("por", z);
    clear_n = 1'b1;

    // Table: parallel loads, serial fills, stall/ignore, back-to-back start.
    for (int i = 0; i < 24; i++) begin
      step($sformatf("vec%0d", i), vec[i].lane_in, vec[i].load, vec[i].start,
           vec[i].valid, vec[i].ser_in, vec[i].exp_out, vec[i].exp_busy, vec[i].exp_done);
    end
`ifdef REGISTER_LANES_PARITY_EN
    chk("parity_01030700", N'(bus_if.parity), N'(4'b1010));
`endif

    // Asynchronous reset between edges with a loaded register.
    step("ld_deadbeef", 32'hDEADBEEF, 4'hF, 0, 0, 8'h00, 32'hDEADBEEF, 0, 0);
    #3;
    clear_n = 1'b0;
    #1;
    chk_state("async_rst", z);
    @(posedge clk);
    #1;
    clear_n = 1'b1;

    // Reset mid-fill after two beats: abort, no done pulse afterwards.
    step("mf_load", 32'h55667788, 4'hF, 0, 0, 8'h00, 32'h55667788, 0, 0);
    step("mf_start", 32'h0, 4'h0, 1, 0, 8'h00, 32'h55667788, 1, 0);
    step("mf_b0", 32'h0, 4'h0, 0, 1, 8'hEE, 32'hEE667788, 1, 0);
    step("mf_b1", 32'h0, 4'h0, 0, 1, 8'hFF, 32'hEEFF7788, 1, 0);
    #2;
    clear_n = 1'b0;
    #1;
    chk_state("mf_rst", z);
    @(posedge clk);
    #1;
    clear_n = 1'b1;
    step("mf_post0", 32'h0, 4'h0, 0, 1, 8'h11, 32'h0, 0, 0);
    step("mf_post1", 32'h0, 4'h0, 0, 1, 8'h22, 32'h0, 0, 0);

    // Fresh fill after abort.
    step("nf_start", 32'h0, 4'h0, 1, 0, 8'h00, 32'h00000000, 1, 0);
    step("nf_b0", 32'h0, 4'h0, 0, 1, 8'hA1, 32'hA1000000, 1, 0);
    step("nf_b1", 32'h0, 4'h0, 0, 1, 8'hB2, 32'hA1B20000, 1, 0);
    step("nf_b2", 32'h0, 4'h0, 0, 1, 8'hC3, 32'hA1B2C300, 1, 0);
    step("nf_b3", 32'h0, 4'h0, 0, 1, 8'hD4, 32'hA1B2C3D4, 0, 1);
    step("nf_idle", 32'h0, 4'h0, 0, 0, 8'h00, 32'hA1B2C3D4, 0, 0);

    if (sb_q.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL sb_drain: %0d entries left, expected 0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
